// File: rtl/hack_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hack_stream_pkg
//  Description : Shared constants for the Hack bit-serial stream blocks
//                (upstream accumulator, word collector, harness).
//  Revision    : 1.0 - initial release
// ============================================================================
package hack_stream_pkg;

    localparam int HACK_WORD_WIDTH        = 16;
    localparam int DEFAULT_FIFO_DEPTH     = 4;
    localparam int DEFAULT_DROP_CNT_WIDTH = 8;

    // Width of a counter holding 0..HACK_WORD_WIDTH bits
    localparam int HACK_BIT_CNT_WIDTH     = $clog2(HACK_WORD_WIDTH) + 1;
    // Width of an occupancy counter holding 0..DEFAULT_FIFO_DEPTH words
    localparam int HACK_LEVEL_WIDTH       = $clog2(DEFAULT_FIFO_DEPTH) + 1;

endpackage
`default_nettype wire

// File: rtl/word_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : word_fifo
//  Description : Parameterised synchronous FIFO with combinational head
//                output and exact occupancy count. A push while full is
//                accepted only when a pop happens on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_fifo
    import hack_stream_pkg::*;
#(
    parameter int WIDTH = HACK_WORD_WIDTH,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int C_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_level;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == (C_AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    // When full, the slot being written is the one being popped this edge
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Storage array: written at the write pointer, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Head is forced to zero while empty so nothing stale is ever presented
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/serial_word_collector.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_collector
//  Description : Assembles a bit-serial stream LSB-first into words, buffers
//                them in a small FIFO behind a valid/ready interface, and
//                keeps debug counters for dropped words and aborted frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_collector
    import hack_stream_pkg::*;
#(
    parameter int WORD_WIDTH     = HACK_WORD_WIDTH,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int DROP_CNT_WIDTH = DEFAULT_DROP_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           bit_in,
    input  logic                           bit_valid,
    input  logic                           frame_sync,
    output logic [WORD_WIDTH-1:0]          word_out,
    output logic                           word_valid,
    input  logic                           word_ready,
    output logic [$clog2(WORD_WIDTH):0]    bit_count,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           overflow,
    output logic [DROP_CNT_WIDTH-1:0]      drop_count,
    output logic [DROP_CNT_WIDTH-1:0]      abort_count
);

    localparam int C_BCW  = $clog2(WORD_WIDTH) + 1;
    localparam int C_IDXW = $clog2(WORD_WIDTH);

    logic [WORD_WIDTH-1:0]     r_shift;
    logic [C_BCW-1:0]          r_bit_count;
    logic                      r_overflow;
    logic [DROP_CNT_WIDTH-1:0] r_drop_count;
    logic [DROP_CNT_WIDTH-1:0] r_abort_count;

    logic                      w_start;
    logic [C_BCW-1:0]          w_pos;
    logic [WORD_WIDTH-1:0]     w_next_word;
    logic                      w_complete;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_drop;
    logic                      w_abort;

    assign w_start = bit_valid & frame_sync;

    // Place the sampled bit: frame_sync restarts the word at position 0
    always_comb begin
        w_pos       = w_start ? '0 : r_bit_count;
        w_next_word = w_start ? '0 : r_shift;
        w_next_word[w_pos[C_IDXW-1:0]] = bit_in;
        w_complete  = bit_valid && (w_pos == C_BCW'(WORD_WIDTH - 1));
    end

    assign w_pop   = ~w_empty & word_ready;
    assign w_drop  = w_complete & w_full & ~w_pop;
    assign w_abort = w_start & (r_bit_count != '0);

    // Shift register and bit counter; a completed word leaves on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= '0;
            r_bit_count <= '0;
        end else if (bit_valid) begin
            if (w_complete) begin
                r_shift     <= '0;
                r_bit_count <= '0;
            end else begin
                r_shift     <= w_next_word;
                r_bit_count <= w_pos + 1'b1;
            end
        end
    end

    // Sticky overflow plus saturating drop and abort counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow    <= 1'b0;
            r_drop_count  <= '0;
            r_abort_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
            if (w_abort && (r_abort_count != '1)) begin
                r_abort_count <= r_abort_count + 1'b1;
            end
        end
    end

    word_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_complete),
        .i_data  (w_next_word),
        .i_pop   (word_ready),
        .o_head  (word_out),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign word_valid  = ~w_empty;
    assign bit_count   = r_bit_count;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;
    assign abort_count = r_abort_count;

endmodule
`default_nettype wire
